ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage in-order core. Consumes the registered decode outputs (aluop, alusel, operands, destination), computes the ALU/shift/multiply result in the same cycle, and runs an iterative 32-step divider that stalls the pipeline until the quotient and remainder are ready. Outputs feed the ex_mem register; stallreq feeds the pipeline control block.

## Interface
- Parameters: none. Widths and opcodes come from the shared defines: RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3.
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- aluop_i  in  8  operation code (EXE_*_OP)
- alusel_i  in  3  result class (EXE_RES_LOGIC / SHIFT / ARITH / MOVE / MUL / NOP)
- reg1_i, reg2_i  in  32  source operands
- wd_i  in  5  destination register address
- wreg_i  in  1  register write request
- hi_i, lo_i  in  32  current HI/LO, already forwarded
- annul_i  in  1  flush the instruction in EX and abort any division
- wd_o  out  5  destination address
- wreg_o  out  1  register write enable
- wdata_o  out  32  register write data
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32  HI/LO write data
- stallreq_o  out  1  hold IF/ID/EX; upstream registers keep their contents while high

## Operation
- Logic ops: AND, OR, XOR, NOR. Shifts: SLL, SRL, SRA; the shift amount is reg1_i[4:0] and the shifted operand is reg2_i.
- Arithmetic ops:
  - ADD/ADDU/SUB/SUBU use 32-bit wrap.
  - On signed overflow, ADD/SUB force wreg_o=0.
  - SLT compares signed; SLTU compares unsigned; the result is 0 or 1.
- MULT/MULTU: single-cycle 64-bit product. hi_o = [63:32], lo_o = [31:0], whilo_o=1, wreg_o=0.
- MFHI/MFLO: wdata_o = hi_i or lo_i.
- MTHI/MTLO: whilo_o=1. The written half comes from reg1_i; the other half passes through from hi_i or lo_i.
- wdata_o is selected by alusel_i. NOP or an unknown class gives wdata_o=0.
- wd_o = wd_i. wreg_o = wreg_i except for the overflow and annul cases.
- DIV/DIVU use div_unit, a restoring divider controlled by an FSM with states IDLE, BUSY, DONE:
  - IDLE → BUSY when the op is DIV/DIVU, annul_i=0, and the divisor is not 0. Operands are latched here; the counter is cleared.
  - IDLE → DONE when the divisor is 0. The result is quotient 0xFFFFFFFF and remainder = dividend.
  - BUSY takes one quotient bit per cycle for 32 cycles, then moves to DONE.
  - DONE presents the result and returns to IDLE on the next cycle.
  - Signed division runs on magnitudes. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Result routing: lo_o = quotient, hi_o = remainder, whilo_o=1 only in DONE.
  - stallreq_o=1 while a DIV/DIVU is in EX and the state is not DONE.
- annul_i=1 forces wreg_o=0, whilo_o=0, stallreq_o=0, and FSM → IDLE on the next edge, from any state.
- Operand changes are ignored while BUSY; the latched copies are used.

## Timing
- Reset (rst=1 at clk edge): FSM=IDLE, counter=0, latched operands=0.
- While rst=1, every output is 0: wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o.
- Non-divide ops are combinational: outputs are valid in the same cycle as the inputs, with 0 added latency.
- DIV, nonzero divisor, first seen in cycle 0:
  - stallreq_o=1 in cycles 0..32.
  - Cycle 33 is DONE: stallreq_o=0, whilo_o=1, result valid.
  - The instruction leaves EX at the end of cycle 33.
- DIV, zero divisor: stallreq_o=1 in cycle 0; DONE in cycle 1.
- Back-to-back DIVs: the second one is recognised in the IDLE cycle after DONE.
- rst or annul_i during BUSY: the divider abandons the operation; no partial result is ever presented.

## Structure
- Defines file holds the opcodes, alusel codes, bus widths, and the divider state encodings (DivIdle, DivBusy, DivDone).
- One sub-module: div_unit, containing the FSM, counter, 65-bit partial remainder, and sign fix-up. Its interface is start, signed, opdata1, opdata2, annul, result[63:0], ready.
- Top level ex_stage: combinational ALU, mux, and DIV start/stall glue.

## Test plan
- ADD 0x7FFFFFFF + 1 → wreg_o=0. ADDU with the same operands → wdata_o=0x80000000, wreg_o=1.
- SRA with reg2=0x80000000, shift amount 4 → wdata_o=0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1; SLT with the same operands → 0.
- MULT 0xFFFFFFFF × 2 (signed) → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, whilo_o=1, same cycle.
- DIV −7 / 2 → stallreq_o high for exactly 33 cycles; then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1 for one cycle.
- DIVU 5 / 0 → DONE after 1 stall cycle with lo_o=0xFFFFFFFF, hi_o=5.
- Abort cases:
  - Start DIVU 100/7 and assert annul_i in cycle 10 → stallreq_o=0 and whilo_o=0 immediately; FSM returns to IDLE.
  - Repeat with rst in cycle 10 → all outputs 0.
  - A following DIVU 100/7 → lo_o=14, hi_o=2.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared bus widths, ALU opcodes, result-class codes and the
// divider state encoding for the execute stage.
package ex_stage_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned RegAddrBus   = 5;
    localparam int unsigned AluOpBus     = 8;
    localparam int unsigned AluSelBus    = 3;
    localparam int unsigned DoubleRegBus = 64;

    // Operation codes
    localparam logic [AluOpBus-1:0] ExeNopOp   = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] ExeAndOp   = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] ExeOrOp    = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] ExeXorOp   = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] ExeNorOp   = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] ExeSllOp   = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] ExeSrlOp   = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] ExeSraOp   = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] ExeMfhiOp  = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] ExeMthiOp  = 8'b0001_0001;
    localparam logic [AluOpBus-1:0] ExeMfloOp  = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] ExeMtloOp  = 8'b0001_0011;
    localparam logic [AluOpBus-1:0] ExeSltOp   = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] ExeSltuOp  = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] ExeAddOp   = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] ExeAdduOp  = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] ExeSubOp   = 8'b0010_0010;
    localparam logic [AluOpBus-1:0] ExeSubuOp  = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] ExeMultOp  = 8'b0001_1000;
    localparam logic [AluOpBus-1:0] ExeMultuOp = 8'b0001_1001;
    localparam logic [AluOpBus-1:0] ExeDivOp   = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] ExeDivuOp  = 8'b0001_1011;

    // Result classes
    localparam logic [AluSelBus-1:0] ExeResNop   = 3'b000;
    localparam logic [AluSelBus-1:0] ExeResLogic = 3'b001;
    localparam logic [AluSelBus-1:0] ExeResShift = 3'b010;
    localparam logic [AluSelBus-1:0] ExeResMove  = 3'b011;
    localparam logic [AluSelBus-1:0] ExeResArith = 3'b100;
    localparam logic [AluSelBus-1:0] ExeResMul   = 3'b101;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivBusy = 2'b01,
        DivDone = 2'b10
    } div_state_e;

    function automatic logic [RegBus-1:0] negate(input logic [RegBus-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        a DIV/DIVU is present in EX
//   signed_i       1 = DIV (signed), 0 = DIVU
//   opdata1_i      dividend
//   opdata2_i      divisor
//   annul_i        abort any division, return to idle
//   result_o       {remainder, quotient}, valid while ready_o
//   ready_o        high for the single DONE cycle
module div_unit
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    signed_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [RegBus-1:0]        divisor_q, divisor_d;
    // {partial remainder[32:0], remaining dividend / growing quotient[31:0]}
    logic [64:0]              part_q, part_d;
    logic                     neg_quo_q, neg_quo_d;
    logic                     neg_rem_q, neg_rem_d;
    logic [DoubleRegBus-1:0]  result_q, result_d;

    logic [RegBus-1:0]        mag1, mag2;
    logic [33:0]              trial;

    assign mag1 = (signed_i && opdata1_i[31]) ? negate(opdata1_i) : opdata1_i;
    assign mag2 = (signed_i && opdata2_i[31]) ? negate(opdata2_i) : opdata2_i;

    // part_q[64:31] is the partial remainder shifted left with the next dividend bit.
    assign trial = part_q[64:31] - {2'b00, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        part_d    = part_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            DivIdle: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        result_d = {opdata1_i, 32'hFFFF_FFFF};
                        state_d  = DivDone;
                    end else begin
                        part_d    = {33'd0, mag1};
                        divisor_d = mag2;
                        neg_quo_d = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d = signed_i & opdata1_i[31];
                        cnt_d     = '0;
                        state_d   = DivBusy;
                    end
                end
            end
            DivBusy: begin
                // Borrow means the divisor does not fit: shift in a 0 quotient bit.
                if (trial[33]) begin
                    part_d = {part_q[63:0], 1'b0};
                end else begin
                    part_d = {trial[32:0], part_q[30:0], 1'b1};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d[63:32] = neg_rem_q ? negate(part_d[63:32]) : part_d[63:32];
                    result_d[31:0]  = neg_quo_q ? negate(part_d[31:0]) : part_d[31:0];
                    state_d         = DivDone;
                end
            end
            DivDone: begin
                state_d = DivIdle;
            end
            default: begin
                state_d = DivIdle;
            end
        endcase

        if (annul_i) begin
            state_d = DivIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivIdle;
            cnt_q     <= '0;
            divisor_q <= '0;
            part_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            part_q    <= part_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = (state_q == DivDone);
    assign result_o = result_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Combinational ALU / shifter / multiplier plus the
// iterative divider, which stalls the pipeline until its result is ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   aluop_i, alusel_i        operation code and result class
//   reg1_i, reg2_i           source operands (reg1_i[4:0] is the shift amount)
//   wd_i, wreg_i             destination and write request
//   hi_i, lo_i               forwarded HI/LO
//   annul_i                  flush the instruction and abort any division
//   wd_o, wreg_o, wdata_o    register write-back
//   whilo_o, hi_o, lo_o      HI/LO write-back
//   stallreq_o               hold IF/ID/EX
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    input  logic                  annul_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  stallreq_o
);

    logic [RegBus-1:0]       logic_res, shift_res, arith_res, move_res;
    logic [RegBus-1:0]       sum_res, diff_res;
    logic                    ov_add, ov_sub;
    logic [DoubleRegBus-1:0] mul_a, mul_b, product;
    logic                    is_div, is_mult;
    logic [DoubleRegBus-1:0] div_result;
    logic                    div_ready;

    assign sum_res  = reg1_i + reg2_i;
    assign diff_res = reg1_i - reg2_i;
    assign ov_add   = (reg1_i[31] == reg2_i[31]) && (sum_res[31] != reg1_i[31]);
    assign ov_sub   = (reg1_i[31] != reg2_i[31]) && (diff_res[31] != reg1_i[31]);

    assign is_mult = (aluop_i == ExeMultOp) || (aluop_i == ExeMultuOp);
    assign is_div  = (aluop_i == ExeDivOp) || (aluop_i == ExeDivuOp);

    // Sign- or zero-extend to 64 bits so a plain 64-bit multiply gives the right product.
    assign mul_a   = (aluop_i == ExeMultuOp) ? {32'd0, reg1_i} : {{32{reg1_i[31]}}, reg1_i};
    assign mul_b   = (aluop_i == ExeMultuOp) ? {32'd0, reg2_i} : {{32{reg2_i[31]}}, reg2_i};
    assign product = mul_a * mul_b;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            ExeAndOp:  logic_res = reg1_i & reg2_i;
            ExeOrOp:   logic_res = reg1_i | reg2_i;
            ExeXorOp:  logic_res = reg1_i ^ reg2_i;
            ExeNorOp:  logic_res = ~(reg1_i | reg2_i);
            ExeSllOp:  shift_res = reg2_i << reg1_i[4:0];
            ExeSrlOp:  shift_res = reg2_i >> reg1_i[4:0];
            ExeSraOp:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            ExeAddOp,
            ExeAdduOp: arith_res = sum_res;
            ExeSubOp,
            ExeSubuOp: arith_res = diff_res;
            ExeSltOp:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            ExeSltuOp: arith_res = {31'd0, reg1_i < reg2_i};
            ExeMfhiOp: move_res  = hi_i;
            ExeMfloOp: move_res  = lo_i;
            default:   ;
        endcase
    end

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_div),
        .signed_i  (aluop_i == ExeDivOp),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .annul_i   (annul_i),
        .result_o  (div_result),
        .ready_o   (div_ready)
    );

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = is_div && !div_ready;

        case (alusel_i)
            ExeResLogic: wdata_o = logic_res;
            ExeResShift: wdata_o = shift_res;
            ExeResArith: wdata_o = arith_res;
            ExeResMove:  wdata_o = move_res;
            ExeResMul:   wdata_o = product[31:0];
            default:     wdata_o = '0;
        endcase

        if (((aluop_i == ExeAddOp) && ov_add) || ((aluop_i == ExeSubOp) && ov_sub) || is_mult) begin
            wreg_o = 1'b0;
        end

        if (is_mult) begin
            whilo_o = 1'b1;
            hi_o    = product[63:32];
            lo_o    = product[31:0];
        end else if (aluop_i == ExeMthiOp) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_i;
        end else if (aluop_i == ExeMtloOp) begin
            whilo_o = 1'b1;
            hi_o    = hi_i;
            lo_o    = reg1_i;
        end else if (is_div && div_ready) begin
            whilo_o = 1'b1;
            hi_o    = div_result[63:32];
            lo_o    = div_result[31:0];
        end

        if (annul_i) begin
            wreg_o     = 1'b0;
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
        end

        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
        end
    end

endmodule
